font_glyph_renderer: RTL and testbench
======================================

FONT_GLYPH_RENDERER -- requirements
Module: font_glyph_renderer

Interface
REQ-001 SHALL have parameter GLYPH_W, default 16, meaning glyph width in pixels.
REQ-002 SHALL have parameter GLYPH_H, default 32, meaning glyph height in pixels; GLYPH_W*GLYPH_H SHALL equal 512.
REQ-003 SHALL have parameters FIRST_CHAR 8'h20, LAST_CHAR 8'h7E and SUB_CHAR 8'h3F, meaning the printable range and the substitute code.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports char_valid (in, 1), char_ready (out, 1) and char_code (in, 8), forming the ASCII input handshake.
REQ-007 SHALL have ports mem_address (out, 7), mem_chipselect (out, 1), mem_clken (out, 1) and mem_readdata (in, 512), forming the glyph-memory read master.
REQ-008 SHALL have ports pix_valid (out, 1), pix_ready (in, 1), pix_data (out, 1), pix_x (out, 4), pix_y (out, 5), pix_last (out, 1) and pix_subst (out, 1), forming the pixel stream.
REQ-009 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, WAIT, STREAM.
REQ-011 SHALL assert char_ready only in IDLE; a char SHALL be accepted when char_valid and char_ready are both high at a clk edge, with the FSM going IDLE->FETCH.
REQ-012 On accept, mem_address SHALL be registered as char_code-FIRST_CHAR for codes 0x20..0x7E; otherwise it SHALL be SUB_CHAR-FIRST_CHAR (31) and the subst flag SHALL be set.
REQ-013 In FETCH, mem_chipselect and mem_clken SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT; both SHALL be 0 in all other states.
REQ-014 In WAIT, mem_readdata SHALL be captured into a 512-bit glyph register, x/y counters SHALL be cleared, and the FSM SHALL go to STREAM.
REQ-015 pix_valid SHALL first be high in the cycle beginning two edges after the accepting edge, giving a latency of 2 cycles.
REQ-016 In STREAM, pix_valid SHALL be 1 and pix_data SHALL be glyph[y*16 + (15-x)], with row 0 at the top and the MSB of each row as the leftmost pixel.
REQ-017 When pix_valid is high and pix_ready is low, pix_data, pix_x, pix_y, pix_last and pix_subst SHALL hold stable.
REQ-018 Each pix_valid&pix_ready edge SHALL increment x; when x wraps 15->0, y SHALL increment.
REQ-019 pix_last SHALL equal 1 exactly at x=15 and y=31; its transfer SHALL return the FSM to IDLE, with char_ready high in the next cycle.
REQ-020 A glyph SHALL produce exactly 512 transfers, and no char SHALL be accepted between acceptance and the pix_last transfer.
REQ-021 pix_subst SHALL equal the latched subst flag for all 512 pixels of the glyph.

Reset
REQ-022 While reset_n=0, the FSM SHALL be IDLE and char_ready=0, pix_valid=0, mem_chipselect=0, mem_clken=0, mem_address=0, pix_x=0, pix_y=0, pix_last=0, pix_subst=0, pix_data=0, busy=0, glyph=0.
REQ-023 After reset_n rises, char_ready SHALL be 1 from the first clk edge onward.
REQ-024 Reset asserted mid-glyph SHALL discard the glyph immediately, and no further pixels of it SHALL be emitted.

Structure
REQ-025 GLYPH_W, GLYPH_H, FIRST_CHAR, LAST_CHAR, SUB_CHAR and the FSM state encoding SHALL reside in the shared package font_pkg.
REQ-026 The block SHALL be a single module with no sub-module; the glyph register and x/y counters SHALL be inline.

Verification
REQ-027 Send 'A' (0x41) with pix_ready=1 -> mem_address=33 with one-cycle chipselect, first pix_valid 2 cycles after accept, 512 pixels matching the memory model, pix_last on transfer 512.
REQ-028 Send 0x0A -> mem_address=31 and pix_subst=1 for all 512 pixels; then send 0x7E -> mem_address=94 and pix_subst=0.
REQ-029 Toggle pix_ready randomly (50%) on glyph 0x20 -> pixel outputs stable while stalled, exactly 512 transfers, x/y wrap sequence correct.
REQ-030 Hold char_valid=1 continuously with codes 0x30, 0x31 -> second char accepted only in the cycle after the first glyph's pix_last transfer, and the codes are not mixed.
REQ-031 Pull reset_n low at pixel 200 -> pix_valid=0 immediately, all outputs at reset values, char_ready=1 after release, and the next glyph complete.

Source files
------------

// File: rtl/font_pkg.sv
// Shared constants and FSM encoding for the glyph renderer.
// Contents: glyph geometry, printable ASCII range, substitute code,
// and the renderer state enum.
package font_pkg;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 32;

  localparam logic [7:0] FIRST_CHAR = 8'h20;
  localparam logic [7:0] LAST_CHAR  = 8'h7E;
  localparam logic [7:0] SUB_CHAR   = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

endpackage

// File: rtl/font_glyph_renderer.sv
// Turns one ASCII code into a raster stream of glyph pixels.
//   clk, reset_n           : clock, async active-low reset
//   char_valid/ready/code  : ASCII input handshake
//   mem_*                  : single-read glyph memory master (1-cycle read latency)
//   pix_*                  : pixel stream, row-major, top row first, MSB leftmost
//   busy                   : high whenever a glyph is in flight
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | ready for the next character
// ST_FETCH  | one-cycle read strobe to glyph memory
// ST_WAIT   | capture read data, clear x/y counters
// ST_STREAM | emit pixels until the pix_last transfer
module font_glyph_renderer #(
  parameter int         GLYPH_W    = font_pkg::GLYPH_W,
  parameter int         GLYPH_H    = font_pkg::GLYPH_H,
  parameter logic [7:0] FIRST_CHAR = font_pkg::FIRST_CHAR,
  parameter logic [7:0] LAST_CHAR  = font_pkg::LAST_CHAR,
  parameter logic [7:0] SUB_CHAR   = font_pkg::SUB_CHAR
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         char_valid,
  output logic         char_ready,
  input  logic [7:0]   char_code,
  output logic [6:0]   mem_address,
  output logic         mem_chipselect,
  output logic         mem_clken,
  input  logic [511:0] mem_readdata,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         pix_data,
  output logic [3:0]   pix_x,
  output logic [4:0]   pix_y,
  output logic         pix_last,
  output logic         pix_subst,
  output logic         busy
);
  import font_pkg::*;

  state_t       state;
  state_t       state_nxt;
  logic         armed;
  logic         subst;
  logic [511:0] glyph;
  logic [3:0]   x_cnt;
  logic [4:0]   y_cnt;
  logic         accept;
  logic         xfer;
  logic         in_range;

  // char_ready must stay low during reset and rise only after the first edge,
  // so it is qualified by a flop rather than by the raw reset pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_WAIT;
      ST_WAIT:   state_nxt = ST_STREAM;
      ST_STREAM: if (xfer && pix_last) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign char_ready     = armed && (state == ST_IDLE);
  assign accept         = char_valid && char_ready;
  assign mem_chipselect = (state == ST_FETCH);
  assign mem_clken      = (state == ST_FETCH);
  assign pix_valid      = (state == ST_STREAM);
  assign xfer           = pix_valid && pix_ready;
  assign busy           = (state != ST_IDLE);
  assign in_range       = (char_code >= FIRST_CHAR) && (char_code <= LAST_CHAR);

  // {y, ~x} == y*16 + (15 - x): leftmost pixel is the row MSB.
  assign pix_data  = glyph[{y_cnt, ~x_cnt}];
  assign pix_x     = x_cnt;
  assign pix_y     = y_cnt;
  assign pix_subst = subst;
  assign pix_last  = pix_valid && (x_cnt == 4'(GLYPH_W - 1)) && (y_cnt == 5'(GLYPH_H - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address <= '0;
      subst       <= 1'b0;
      glyph       <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
    end else begin
      if (accept) begin
        mem_address <= in_range ? 7'(char_code - FIRST_CHAR) : 7'(SUB_CHAR - FIRST_CHAR);
        subst       <= !in_range;
      end
      if (state == ST_WAIT) begin
        glyph <= mem_readdata;
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (xfer) begin
        if (x_cnt == 4'(GLYPH_W - 1)) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 5'd1;
        end else begin
          x_cnt <= x_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_font_glyph_renderer.sv
module tb_font_glyph_renderer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         char_valid = 1'b0;
  logic         char_ready;
  logic [7:0]   char_code = 8'h00;
  logic [6:0]   mem_address;
  logic         mem_chipselect;
  logic         mem_clken;
  logic [511:0] mem_readdata = '0;
  logic         pix_valid;
  logic         pix_ready = 1'b0;
  logic         pix_data;
  logic [3:0]   pix_x;
  logic [4:0]   pix_y;
  logic         pix_last;
  logic         pix_subst;
  logic         busy;

  int total = 0;
  int bad   = 0;

  font_glyph_renderer dut (
    .clk(clk), .reset_n(reset_n),
    .char_valid(char_valid), .char_ready(char_ready), .char_code(char_code),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .pix_subst(pix_subst),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Glyph memory model: distinct pseudo-random pattern per address.
  function automatic logic [511:0] rom_glyph(input logic [6:0] a);
    logic [511:0] g;
    for (int w = 0; w < 16; w++)
      g[w*32 +: 32] = (32'(a) * 32'h0100_0193 + 32'(w) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    return g;
  endfunction

  always @(posedge clk)
    if (mem_chipselect && mem_clken) mem_readdata <= rom_glyph(mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_char_ready"}, 32'(char_ready), 0);
    chk({tag, "_pix_valid"},  32'(pix_valid), 0);
    chk({tag, "_cs"},         32'(mem_chipselect), 0);
    chk({tag, "_clken"},      32'(mem_clken), 0);
    chk({tag, "_addr"},       32'(mem_address), 0);
    chk({tag, "_x"},          32'(pix_x), 0);
    chk({tag, "_y"},          32'(pix_y), 0);
    chk({tag, "_last"},       32'(pix_last), 0);
    chk({tag, "_subst"},      32'(pix_subst), 0);
    chk({tag, "_data"},       32'(pix_data), 0);
    chk({tag, "_busy"},       32'(busy), 0);
  endtask

  // Wait for char_ready, present code, return just after the accepting edge.
  task automatic send_char(input logic [7:0] code, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!char_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) chk("ready_timeout", 32'(char_ready), 1);
    char_valid = 1'b1;
    char_code  = code;
    @(posedge clk);
    #1;
    if (!hold) char_valid = 1'b0;
  endtask

  // Checks the FETCH and WAIT cycles following an accept edge.
  task automatic check_fetch(input logic [6:0] exp_addr);
    @(negedge clk);
    chk("fetch_cs",    32'(mem_chipselect), 1);
    chk("fetch_clken", 32'(mem_clken), 1);
    chk("fetch_addr",  32'(mem_address), 32'(exp_addr));
    chk("fetch_pv",    32'(pix_valid), 0);
    chk("fetch_ready", 32'(char_ready), 0);
    chk("fetch_busy",  32'(busy), 1);
    @(negedge clk);
    chk("wait_cs",     32'(mem_chipselect), 0);
    chk("wait_clken",  32'(mem_clken), 0);
    chk("wait_pv",     32'(pix_valid), 0);
    chk("wait_busy",   32'(busy), 1);
  endtask

  // Streams up to stop_at transfers, checking every pixel cycle (stalls included).
  task automatic stream(input logic [6:0] exp_addr, input logic exp_subst,
                        input bit rand_ready, input int stop_at);
    logic [511:0] g;
    int n = 0;
    int cyc = 0;
    int ex, ey;
    g = rom_glyph(exp_addr);
    while (n < stop_at && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ex = n % 16;
      ey = n / 16;
      chk("pix_valid", 32'(pix_valid), 1);
      chk("pix_x",     32'(pix_x), 32'(ex));
      chk("pix_y",     32'(pix_y), 32'(ey));
      chk("pix_data",  32'(pix_data), 32'(g[ey*16 + (15 - ex)]));
      chk("pix_last",  32'(pix_last), 32'(n == 511));
      chk("pix_subst", 32'(pix_subst), 32'(exp_subst));
      chk("no_accept", 32'(char_ready), 0);
      chk("cs_idle",   32'(mem_chipselect), 0);
      chk("addr_hold", 32'(mem_address), 32'(exp_addr));
      if (pix_ready) n++;
    end
    chk("xfer_count", 32'(n), 32'(stop_at));
  endtask

  // Cycle after the pix_last transfer: back in IDLE.
  task automatic tail_check();
    @(negedge clk);
    pix_ready = 1'b0;
    chk("tail_pv",    32'(pix_valid), 0);
    chk("tail_ready", 32'(char_ready), 1);
    chk("tail_busy",  32'(busy), 0);
  endtask

  typedef struct {
    logic [7:0] code;
    logic [6:0] addr;
    logic       subst;
    bit         rand_ready;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h41, 7'd33, 1'b0, 1'b0};
    vecs[1] = '{8'h0A, 7'd31, 1'b1, 1'b0};
    vecs[2] = '{8'h7E, 7'd94, 1'b0, 1'b0};
    vecs[3] = '{8'h20, 7'd0,  1'b0, 1'b1};
    vecs[4] = '{8'h1F, 7'd31, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 7'd31, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 7'd31, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(char_ready), 1);
    chk("post_rst_busy",  32'(busy), 0);

    // Table-driven glyphs
    for (int i = 0; i < 7; i++) begin
      send_char(vecs[i].code, 1'b0);
      check_fetch(vecs[i].addr);
      stream(vecs[i].addr, vecs[i].subst, vecs[i].rand_ready, 512);
      tail_check();
    end

    // char_valid held across two codes: second accepted only after pix_last
    send_char(8'h30, 1'b1);
    char_code = 8'h31;
    check_fetch(7'd16);
    stream(7'd16, 1'b0, 1'b0, 512);
    tail_check();
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    check_fetch(7'd17);
    stream(7'd17, 1'b0, 1'b0, 512);
    tail_check();

    // Reset mid-glyph at pixel 200
    send_char(8'h48, 1'b0);
    check_fetch(7'd40);
    stream(7'd40, 1'b0, 1'b0, 200);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(char_ready), 1);
    chk("mid_rst_pv",    32'(pix_valid), 0);
    send_char(8'h48, 1'b0);
    check_fetch(7'd40);
    stream(7'd40, 1'b0, 1'b0, 512);
    tail_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
